imem_loader: RTL and testbench

Writes a program into the instruction memory that the fetch path (PC + instruction memory) reads. Bytes arrive on a valid/ready stream, are packed into big-endian 32-bit words and written to word addresses 0, 1, 2, … of the instruction memory. The fetch path uses the same word addressing, with PC incrementing by 1. While loading, the block holds the CPU via `cpu_hold`. It releases the CPU when the requested word count has been written.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to
// instruction memory from word address 0 upward, holding the CPU until the load ends.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic [ADDR_WIDTH:0]   count_sat;
  logic [ADDR_WIDTH:0]   next_idx;
  logic [31:0]           asm_shifted;
  logic                  byte_accept;

  // The index is one bit wider than the address so a full-capacity load ends
  // by comparing against 2^ADDR_WIDTH instead of wrapping back to address 0.
  assign count_sat   = (word_count > CAPACITY) ? CAPACITY : word_count;
  assign next_idx    = idx_q + IDX_ONE;
  assign asm_shifted = {asm_q[23:0], byte_in};
  assign byte_accept = byte_valid && byte_ready_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    byte_ready_d = byte_ready_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cpu_hold_d   = cpu_hold_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d    = count_sat;
          idx_d      = '0;
          byte_cnt_d = 2'd0;
          wr_addr_d  = '0;
          if (count_sat == '0) begin
            state_d      = S_DONE;
            byte_ready_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            cpu_hold_d   = 1'b0;
          end else begin
            state_d      = S_RECV;
            byte_ready_d = 1'b1;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            cpu_hold_d   = 1'b1;
          end
        end
      end

      S_RECV: begin
        if (byte_accept) begin
          asm_d      = asm_shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d      = S_WRITE;
            byte_ready_d = 1'b0;
            wr_en_d      = 1'b1;
            wr_addr_d    = idx_q[ADDR_WIDTH-1:0];
            wr_data_d    = asm_shifted;
          end
        end
      end

      S_WRITE: begin
        idx_d      = next_idx;
        byte_cnt_d = 2'd0;
        if (next_idx == count_q) begin
          state_d      = S_DONE;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cpu_hold_d   = 1'b0;
        end else begin
          state_d      = S_RECV;
          byte_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, hand-written reset and
// timing sequences, and randomized loads compared against a word-list reference model.
module tb_imem_loader;

  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          cpu_hold;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  bit mon_en   = 0;

  logic [AW-1:0] act_addr[$];
  logic [31:0]   act_data[$];
  int            act_cyc[$];
  logic [31:0]   src_words[$];
  logic [7:0]    byte_q[$];
  int            last_start_cyc;
  int            last_done_cyc;
  int            write_base;
  int            busy_base;

  typedef struct {
    logic [AW:0] count_in;
    int          valid_pct;
    bit          alt;
    int          restart_at;
    int          exp_writes;
  } load_vec_t;

  load_vec_t tbl[8];

  // Free-running clock with a cycle counter used to measure latencies
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: logs every write and checks invariants that hold in every state
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (wr_en) begin
        act_addr.push_back(wr_addr);
        act_data.push_back(wr_data);
        act_cyc.push_back(cyc);
      end
      if (busy) busy_cnt++;
      checkOutput("ready_during_write", {31'd0, wr_en && byte_ready}, 32'd0);
      checkOutput("hold_is_not_done", {31'd0, cpu_hold}, {31'd0, !done});
      checkOutput("busy_and_done", {31'd0, busy && done}, 32'd0);
    end
  end

  // Runs one complete load from the current state; the reference model is the
  // list src_words[0 .. min(count, CAP)-1] written to addresses 0, 1, 2, ...
  task automatic applyStimulus(input logic [AW:0] cnt, input int valid_pct, input bit alt,
                               input int restart_at);
    int          n;
    int          popped;
    bit          finished;
    bit          acc;
    bit          restarted;
    logic [31:0] wv;
    n = (int'(cnt) > CAP) ? CAP : int'(cnt);
    byte_q.delete();
    for (int w = 0; w < n; w++) begin
      wv = src_words[w];
      for (int b = 0; b < 4; b++) byte_q.push_back(8'(wv >> (24 - 8 * b)));
    end
    write_base = act_addr.size();
    busy_base  = busy_cnt;
    start = 1'b1;
    word_count = cnt;
    last_start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (n > 0) begin
      checkOutput("start_clears_done", {31'd0, done}, 32'd0);
      checkOutput("start_sets_hold", {31'd0, cpu_hold}, 32'd1);
      checkOutput("start_sets_ready", {31'd0, byte_ready}, 32'd1);
    end else begin
      checkOutput("zero_count_done", {31'd0, done}, 32'd1);
    end
    popped = 0;
    finished = 0;
    restarted = 0;
    last_done_cyc = -1;
    for (int k = 0; k < 4000 && !finished; k++) begin
      byte_valid = (byte_q.size() > 0) && (alt ? (k % 2 == 1) : ($urandom_range(99, 0) < valid_pct));
      byte_in = byte_valid ? byte_q[0] : 8'($urandom);
      if (!restarted && restart_at >= 0 && popped >= restart_at) begin
        start = 1'b1;
        word_count = 5'd5;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done && !start) begin
        finished = 1;
        last_done_cyc = cyc;
      end
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) begin
        void'(byte_q.pop_front());
        popped++;
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
    checkOutput("load_finished", {31'd0, finished}, 32'd1);
    checkOutput("bytes_unconsumed", byte_q.size(), 32'd0);
    checkOutput("write_count", act_addr.size() - write_base, n);
    for (int i = 0; i < n && write_base + i < act_addr.size(); i++) begin
      checkOutput("write_addr", {28'd0, act_addr[write_base + i]}, i);
      checkOutput("write_data", act_data[write_base + i], src_words[i]);
    end
  endtask

  task automatic fillWords();
    src_words.delete();
    for (int i = 0; i < CAP; i++) src_words.push_back($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{count_in: 5'd2,  valid_pct: 100, alt: 0, restart_at: -1, exp_writes: 2};
    tbl[1] = '{count_in: 5'd1,  valid_pct: 100, alt: 1, restart_at: -1, exp_writes: 1};
    tbl[2] = '{count_in: 5'd0,  valid_pct: 100, alt: 0, restart_at: -1, exp_writes: 0};
    tbl[3] = '{count_in: 5'd1,  valid_pct: 100, alt: 0, restart_at: 2,  exp_writes: 1};
    tbl[4] = '{count_in: 5'd1,  valid_pct: 60,  alt: 0, restart_at: -1, exp_writes: 1};
    tbl[5] = '{count_in: 5'd16, valid_pct: 80,  alt: 0, restart_at: -1, exp_writes: 16};
    tbl[6] = '{count_in: 5'd31, valid_pct: 70,  alt: 0, restart_at: -1, exp_writes: 16};
    tbl[7] = '{count_in: 5'd17, valid_pct: 90,  alt: 0, restart_at: -1, exp_writes: 16};

    // Reset held two cycles with a byte offered: nothing may be accepted
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("reset_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("reset_wr_addr", {28'd0, wr_addr}, 32'd0);
    checkOutput("reset_wr_data", wr_data, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Table of whole loads; entries 0 and 1 use the fixed words from the test plan
    for (int i = 0; i < 8; i++) begin
      fillWords();
      if (i == 0) begin
        src_words[0] = 32'h0000_0005;
        src_words[1] = 32'h1234_5678;
      end
      if (i == 1) src_words[0] = 32'hDEAD_BEEF;
      applyStimulus(tbl[i].count_in, tbl[i].valid_pct, tbl[i].alt, tbl[i].restart_at);
      checkOutput("table_writes", act_addr.size() - write_base, tbl[i].exp_writes);
      if (i == 0 && act_cyc.size() >= write_base + 2) begin
        checkOutput("first_write_cycle", act_cyc[write_base] - last_start_cyc, 32'd5);
        checkOutput("second_write_cycle", act_cyc[write_base + 1] - last_start_cyc, 32'd10);
        checkOutput("done_cycle", last_done_cyc - last_start_cyc, 32'd11);
      end
      if (tbl[i].exp_writes == 0) checkOutput("zero_count_busy", busy_cnt - busy_base, 32'd0);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end

    // Reset after two bytes of a word: the partial word must vanish
    write_base = act_addr.size();
    start = 1'b1;
    word_count = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    @(posedge clk); #1;
    byte_in = 8'hBB;
    @(posedge clk); #1;
    byte_in = 8'hCC;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    byte_in = 8'hDD;
    checkOutput("midreset_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    checkOutput("midreset_no_write", act_addr.size() - write_base, 32'd0);
    fillWords();
    src_words[0] = 32'h1122_3344;
    applyStimulus(5'd1, 100, 0, -1);

    // Randomized loads, each checked against the word-list model
    for (int r = 0; r < 15; r++) begin
      fillWords();
      applyStimulus(5'($urandom_range(31, 0)), int'($urandom_range(100, 30)), 0, -1);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
